vga_console: RTL and testbench
==============================

# vga_console

Character-stream console engine for the 40x30 two-byte-per-cell text display. Consumes bytes over a valid/ready handshake and maintains a cursor. Generates every write into the display's 2048-entry video RAM write port: character cells, clear-screen fills and line blanking. Scrolling is done in hardware through a `top_row` offset that the display pipeline adds to its row fetch, so the engine never reads video RAM back.

## Interface
- `COLS`, 40, columns per row
- `ROWS`, 30, rows per screen
- `AW`, 11, video RAM address width
- `clk`  in  1  pixel/system clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `in_data`  in  8  character or control byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  engine accepts a byte this cycle
- `attr`  in  8  attribute byte; sampled with every accepted byte
- `vram_waddr`  out  AW  video RAM write address
- `vram_wdata`  out  16  `{attr, char}` cell data
- `vram_we`  out  1  write strobe, one cell per cycle
- `top_row`  out  5  physical row shown as screen row 0 (0..ROWS-1)
- `cur_col`  out  6  cursor column (0..COLS-1)
- `cur_row`  out  5  cursor logical row (0..ROWS-1)
- `busy`  out  1  high whenever `in_ready` is low

## Operation
- States: IDLE, PUT, CLRLINE, CLEAR.
- A byte is accepted only in IDLE when `in_valid & in_ready`. `in_ready` = (state==IDLE).
- Accepted byte 0x20..0x7E goes to PUT. PUT writes `{attr_q, byte}` at the cursor, then advances `cur_col`.
  - If the column passes `COLS-1`: `cur_col`=0 and a newline is performed.
- 0x0A (LF): `cur_col`=0, newline. 0x0D (CR): `cur_col`=0. 0x08 (BS): `cur_col` decrements if >0, with no write.
- 0x0C (FF): `cur_col`=`cur_row`=`top_row`=0, then go to CLEAR. Any other byte is consumed with no effect.
- Newline:
  - If `cur_row` < ROWS-1: `cur_row`++ and return to IDLE.
  - Otherwise: the old `top_row` becomes the new bottom row; set `top_row` = (`top_row`+1) mod ROWS, then go to CLRLINE.
- CLRLINE writes `{attr_q, 8'h20}` to all COLS cells of the new bottom row, columns 0..COLS-1 in order, then returns to IDLE.
- CLEAR writes `{attr_q, 8'h20}` to addresses 0..COLS*ROWS-1 (0..1199) in order, then returns to IDLE. Addresses 1200..2047 are never written.
- Address: `phys` = `cur_row` + `top_row`, minus ROWS if ≥ ROWS; `vram_waddr` = `phys`*40 + col. Use shift-add (`phys`<<5 + `phys`<<3); no multiplier.
- `attr_q` is captured on every accepted byte and resets to 8'h0F.
- Reset:
  - Values: all outputs 0 except `busy`=1; `attr_q`=8'h0F.
  - On release, the engine enters CLEAR, so the screen is blanked after power-up.
  - Reset asserted mid-PUT/CLRLINE/CLEAR aborts the operation. `vram_we` is 0 in the reset cycle and the fill restarts from address 0.

## Timing
- `vram_waddr`, `vram_wdata` and `vram_we` are registered; the write presents in the cycle after the state decision.
- Printable byte accepted at cycle N: the write is at N+1 and `in_ready` is high again at N+2 (when no scroll). Peak throughput is 1 byte per 2 cycles.
- Control bytes without a fill (CR, BS, LF without scroll, ignored bytes): `in_ready` returns at N+1.
- Cursor and `top_row` outputs update in the same cycle as the associated write (PUT), or at N+1 for control bytes.
- Scroll after wrap on the last row: PUT write at N+1, CLRLINE writes at N+2..N+41, `in_ready` high at N+42. `top_row` changes at N+1.
- LF with scroll: CLRLINE writes at N+1..N+40, `in_ready` at N+41.
- CLEAR: 1200 consecutive write cycles, with `in_ready` high the cycle after the last write. This gives 1201 busy cycles after FF, or after reset release.
- `top_row` wraps 29→0. Physical row computation wraps modulo ROWS in the same cycle.

## Structure
- Shared package `vga_console_pkg`:
  - `COLS`, `ROWS`, `CELLS`
  - character constants LF, CR, BS, FF, SPACE
  - reset attribute 8'h0F
  - state enum
- Sub-module `vga_cell_addr`: combinational (`row`, `top_row`, `col`) → AW-bit address with modulo-ROWS wrap. It is reusable by the display-side fetch.
- Fill counter: one 11-bit counter shared by CLEAR and CLRLINE.

## Test plan
- Reset release: exactly 1200 writes, addr 0..1199, data 16'h0F20; `in_ready` rises on the next cycle; no address ≥1200.
- Bytes 0x41 then 0x42 with `attr`=0x1E: writes 16'h1E41@0 and 16'h1E42@1; `cur_col`=2; `in_ready` low for one cycle after each accept.
- 40 printables on row 29 (`top_row`=0): 40th written @1199; `top_row`→1; row 0 cleared @0..39 with `{attr,0x20}`; cursor (0,29); next char written @1160−1160+… i.e. `phys` row 0 → addr 0.
- With `top_row`=29, cursor (5,1): byte 0x58 writes @(0*40+5)=5 (physical row wraps).
- FF mid-screen: cursor/`top_row` reset to 0, 1200 blank writes. Assert `reset_n` low at fill cell 600: no write in reset cycle, fill restarts at 0.
- CR, BS at col 0, BS at col 3, byte 0x07: no writes; `cur_col`=0,0,2,2 respectively; `in_ready` back after 1 cycle.

Source files
------------

// File: rtl/vga_console_pkg.sv
// Shared constants, control characters and FSM state type for the 40x30 text console.
package vga_console_pkg;

  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [7:0] ATTR_RESET = 8'h0F;

  typedef enum logic [1:0] {
    StIdle,
    StPut,
    StClrLine,
    StClear
  } state_e;

  // Bytes that are written to the screen as glyphs.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_cell_addr.sv
// Logical (row, col) plus scroll offset to video RAM cell address. Purely combinational,
// so the display-side fetch can reuse it.
module vga_cell_addr
  import vga_console_pkg::*;
#(
  parameter int unsigned AW = 11
) (
  input  logic [4:0]    i_row,
  input  logic [4:0]    i_top_row,
  input  logic [5:0]    i_col,
  output logic [AW-1:0] o_addr
);

  logic [5:0] w_sum;
  logic [4:0] w_phys;

  assign w_sum = {1'b0, i_row} + {1'b0, i_top_row};

  // Physical row wraps modulo ROWS; both inputs are below ROWS so one subtraction suffices.
  always_comb begin
    w_phys = w_sum[4:0];
    if (w_sum >= 6'(ROWS)) begin
      w_phys = 5'(w_sum - 6'(ROWS));
    end
  end

  // phys*40 as phys*32 + phys*8.
  assign o_addr = AW'({w_phys, 5'b0_0000}) + AW'({w_phys, 3'b000}) + AW'(i_col);

endmodule

// File: rtl/vga_console.sv
// Character-stream console engine: consumes bytes, tracks the cursor, and issues every
// video RAM write (glyphs, full-screen clear, bottom-line blanking on scroll).
module vga_console
  import vga_console_pkg::*;
#(
  parameter int unsigned AW = 11
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [7:0]    i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [7:0]    i_attr,
  output logic [AW-1:0] o_vram_waddr,
  output logic [15:0]   o_vram_wdata,
  output logic          o_vram_we,
  output logic [4:0]    o_top_row,
  output logic [5:0]    o_cur_col,
  output logic [4:0]    o_cur_row,
  output logic          o_busy
);

  state_e        r_state,  w_state_nxt;
  logic [7:0]    r_attr,   w_attr_nxt;
  logic [5:0]    r_col,    w_col_nxt;
  logic [4:0]    r_row,    w_row_nxt;
  logic [4:0]    r_top,    w_top_nxt;
  logic [10:0]   r_fill,   w_fill_nxt;
  logic          r_scroll, w_scroll_nxt;
  logic [AW-1:0] r_waddr,  w_waddr_nxt;
  logic [15:0]   r_wdata,  w_wdata_nxt;
  logic          r_we,     w_we_nxt;

  logic [4:0]    w_top_inc;
  logic          w_last_row;
  logic [4:0]    w_addr_top;
  logic [5:0]    w_addr_col;
  logic [AW-1:0] w_cell_addr;

  assign w_top_inc  = (r_top == 5'(ROWS - 1)) ? 5'd0 : r_top + 5'd1;
  assign w_last_row = (r_row == 5'(ROWS - 1));

  // Address source select: the cursor row is always used; the scroll paths need the
  // post-scroll top row (so row ROWS-1 lands on the old top) and the fill column.
  always_comb begin
    w_addr_top = r_top;
    w_addr_col = r_col;
    case (r_state)
      StIdle: begin
        if (i_in_data == CH_LF) begin
          w_addr_top = w_top_inc;
          w_addr_col = 6'd0;
        end
      end
      StPut:     w_addr_col = 6'd0;
      StClrLine: w_addr_col = r_fill[5:0];
      default:   ;
    endcase
  end

  vga_cell_addr #(
    .AW (AW)
  ) u_cell_addr (
    .i_row     (r_row),
    .i_top_row (w_addr_top),
    .i_col     (w_addr_col),
    .o_addr    (w_cell_addr)
  );

  // Next-state, cursor and registered write-port decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_attr_nxt   = r_attr;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_top_nxt    = r_top;
    w_fill_nxt   = r_fill;
    w_scroll_nxt = r_scroll;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_attr_nxt = i_attr;
          if (is_printable(i_in_data)) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_cell_addr;
            w_wdata_nxt = {i_attr, i_in_data};
            w_state_nxt = StPut;
            if (r_col == 6'(COLS - 1)) begin
              w_col_nxt = 6'd0;
              if (!w_last_row) begin
                w_row_nxt = r_row + 5'd1;
              end else begin
                // Line blanking follows in PUT, after the glyph write.
                w_top_nxt    = w_top_inc;
                w_scroll_nxt = 1'b1;
              end
            end else begin
              w_col_nxt = r_col + 6'd1;
            end
          end else begin
            case (i_in_data)
              CH_LF: begin
                w_col_nxt = 6'd0;
                if (!w_last_row) begin
                  w_row_nxt = r_row + 5'd1;
                end else begin
                  // First blank cell issued now; CLRLINE covers the rest.
                  w_top_nxt   = w_top_inc;
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = w_cell_addr;
                  w_wdata_nxt = {i_attr, CH_SPACE};
                  w_fill_nxt  = 11'd1;
                  w_state_nxt = StClrLine;
                end
              end
              CH_CR: w_col_nxt = 6'd0;
              CH_BS: begin
                if (r_col != 6'd0) begin
                  w_col_nxt = r_col - 6'd1;
                end
              end
              CH_FF: begin
                w_col_nxt   = 6'd0;
                w_row_nxt   = 5'd0;
                w_top_nxt   = 5'd0;
                w_fill_nxt  = 11'd0;
                w_state_nxt = StClear;
              end
              default: ;
            endcase
          end
        end
      end

      StPut: begin
        w_scroll_nxt = 1'b0;
        if (r_scroll) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_cell_addr;
          w_wdata_nxt = {r_attr, CH_SPACE};
          w_fill_nxt  = 11'd1;
          w_state_nxt = StClrLine;
        end else begin
          w_state_nxt = StIdle;
        end
      end

      StClrLine: begin
        if (r_fill == 11'(COLS)) begin
          w_state_nxt = StIdle;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_cell_addr;
          w_wdata_nxt = {r_attr, CH_SPACE};
          w_fill_nxt  = r_fill + 11'd1;
        end
      end

      StClear: begin
        if (r_fill == 11'(CELLS)) begin
          w_state_nxt = StIdle;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = AW'(r_fill);
          w_wdata_nxt = {r_attr, CH_SPACE};
          w_fill_nxt  = r_fill + 11'd1;
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers; reset lands in CLEAR so the screen is blanked on release.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= StClear;
      r_attr   <= ATTR_RESET;
      r_col    <= 6'd0;
      r_row    <= 5'd0;
      r_top    <= 5'd0;
      r_fill   <= 11'd0;
      r_scroll <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= 16'd0;
      r_we     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_attr   <= w_attr_nxt;
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_top    <= w_top_nxt;
      r_fill   <= w_fill_nxt;
      r_scroll <= w_scroll_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
    end
  end

  assign o_in_ready   = (r_state == StIdle);
  assign o_busy       = ~o_in_ready;
  assign o_vram_waddr = r_waddr;
  assign o_vram_wdata = r_wdata;
  assign o_vram_we    = r_we;
  assign o_top_row    = r_top;
  assign o_cur_col    = r_col;
  assign o_cur_row    = r_row;

endmodule

// File: tb/tb_vga_console.sv
// Directed self-checking bench for vga_console.
module tb_vga_console;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  logic [10:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic        vram_we;
  logic [4:0]  top_row;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [10:0] q_addr[$];
  logic [15:0] q_data[$];

  vga_console #(
    .AW (11)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_attr       (attr),
    .o_vram_waddr (vram_waddr),
    .o_vram_wdata (vram_wdata),
    .o_vram_we    (vram_we),
    .o_top_row    (top_row),
    .o_cur_col    (cur_col),
    .o_cur_row    (cur_row),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every write presented on the port, sampled mid-cycle.
  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      q_addr.push_back(vram_waddr);
      q_data.push_back(vram_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  // Bounded wait for in_ready; returns number of cycles waited.
  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Present one byte; returns one cycle after the accepting edge.
  task automatic send(input logic [7:0] b, input logic [7:0] a);
    int n;
    wait_ready(5000, n);
    chk("send_ready", 32'(in_ready), 32'd1);
    in_data  = b;
    attr     = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Check a contiguous run of fill writes starting at queue index first.
  task automatic chk_fill(input string tag, input int first, input int count, input int base,
                          input logic [15:0] data);
    int bad;
    bad = 0;
    for (int i = 0; i < count; i++) begin
      if (first + i >= q_addr.size()) bad++;
      else if (q_addr[first+i] !== 11'(base + i) || q_data[first+i] !== data) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    attr     = 8'h00;
    repeat (3) tick();

    // Reset state
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_addr", 32'(vram_waddr), 32'd0);
    chk("rst_data", 32'(vram_wdata), 32'd0);
    chk("rst_cursor", {21'd0, top_row, cur_row, cur_col}, 32'd0);

    // Power-up clear
    clear_q();
    reset_n = 1'b1;
    wait_ready(2000, n);
    chk("pu_busy_cycles", 32'(n), 32'd1201);
    chk("pu_nwrites", 32'(q_addr.size()), 32'd1200);
    chk_fill("pu_fill", 0, 1200, 0, 16'h0F20);

    // Two printables
    send(8'h41, 8'h1E);
    chk("a_we", 32'(vram_we), 32'd1);
    chk("a_addr", 32'(vram_waddr), 32'd0);
    chk("a_data", 32'(vram_wdata), 32'h1E41);
    chk("a_ready_low", 32'(in_ready), 32'd0);
    chk("a_col", 32'(cur_col), 32'd1);
    tick();
    chk("a_ready_back", 32'(in_ready), 32'd1);
    send(8'h42, 8'h1E);
    chk("b_addr", 32'(vram_waddr), 32'd1);
    chk("b_data", 32'(vram_wdata), 32'h1E42);
    chk("b_col", 32'(cur_col), 32'd2);
    tick();
    chk("b_ready_back", 32'(in_ready), 32'd1);

    // Control bytes without writes
    send(8'h0D, 8'h1E);
    chk("cr_col", 32'(cur_col), 32'd0);
    chk("cr_ready", 32'(in_ready), 32'd1);
    chk("cr_we", 32'(vram_we), 32'd0);
    send(8'h08, 8'h1E);
    chk("bs0_col", 32'(cur_col), 32'd0);
    chk("bs0_ready", 32'(in_ready), 32'd1);
    send(8'h61, 8'h1E);
    send(8'h62, 8'h1E);
    send(8'h63, 8'h1E);
    tick();
    clear_q();
    send(8'h08, 8'h1E);
    chk("bs3_col", 32'(cur_col), 32'd2);
    chk("bs3_ready", 32'(in_ready), 32'd1);
    send(8'h07, 8'h1E);
    chk("bel_col", 32'(cur_col), 32'd2);
    chk("bel_ready", 32'(in_ready), 32'd1);
    tick();
    chk("ctl_nwrites", 32'(q_addr.size()), 32'd0);

    // Move to last row, fill it, wrap and scroll
    for (int i = 0; i < 29; i++) send(8'h0A, 8'h2A);
    chk("lf_row", 32'(cur_row), 32'd29);
    chk("lf_col", 32'(cur_col), 32'd0);
    for (int i = 0; i < 39; i++) send(8'h5A, 8'h2A);
    chk("z39_col", 32'(cur_col), 32'd39);
    tick();
    clear_q();
    send(8'h5A, 8'h2A);
    chk("wrap_addr", 32'(vram_waddr), 32'd1199);
    chk("wrap_data", 32'(vram_wdata), 32'h2A5A);
    chk("wrap_top", 32'(top_row), 32'd1);
    chk("wrap_cursor", {26'd0, cur_col}, 32'd0);
    chk("wrap_row", 32'(cur_row), 32'd29);
    wait_ready(200, n);
    chk("wrap_busy", 32'(n), 32'd41);
    chk("wrap_nwrites", 32'(q_addr.size()), 32'd41);
    chk_fill("wrap_clr", 1, 40, 0, 16'h2A20);
    send(8'h51, 8'h2A);
    chk("q_addr", 32'(vram_waddr), 32'd0);
    chk("q_data", 32'(vram_wdata), 32'h2A51);
    chk("q_col", 32'(cur_col), 32'd1);

    // LF with scroll
    wait_ready(10, n);
    clear_q();
    send(8'h0A, 8'h33);
    chk("lfs_we", 32'(vram_we), 32'd1);
    chk("lfs_addr", 32'(vram_waddr), 32'd40);
    chk("lfs_data", 32'(vram_wdata), 32'h3320);
    chk("lfs_top", 32'(top_row), 32'd2);
    chk("lfs_col", 32'(cur_col), 32'd0);
    wait_ready(200, n);
    chk("lfs_busy", 32'(n), 32'd40);
    chk("lfs_nwrites", 32'(q_addr.size()), 32'd40);
    chk_fill("lfs_clr", 0, 40, 40, 16'h3320);

    // Scroll to top_row 29, then write where the physical row wraps
    for (int i = 0; i < 27; i++) send(8'h0A, 8'h33);
    wait_ready(200, n);
    chk("t29_top", 32'(top_row), 32'd29);
    for (int i = 0; i < 5; i++) send(8'h61, 8'h33);
    send(8'h58, 8'h55);
    chk("t29_addr", 32'(vram_waddr), 32'd1125);
    chk("t29_data", 32'(vram_wdata), 32'h5558);
    send(8'h0A, 8'h55);
    chk("twrap_top", 32'(top_row), 32'd0);
    chk("twrap_addr", 32'(vram_waddr), 32'd1160);
    wait_ready(200, n);
    chk("twrap_busy", 32'(n), 32'd40);

    // Form feed, then reset in the middle of the fill
    send(8'h0C, 8'h44);
    chk("ff_cursor", {21'd0, top_row, cur_row, cur_col}, 32'd0);
    chk("ff_ready", 32'(in_ready), 32'd0);
    chk("ff_we", 32'(vram_we), 32'd0);
    repeat (601) tick();
    chk("ff600_we", 32'(vram_we), 32'd1);
    chk("ff600_addr", 32'(vram_waddr), 32'd600);
    chk("ff600_data", 32'(vram_wdata), 32'h4420);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_we", 32'(vram_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    clear_q();
    reset_n = 1'b1;
    wait_ready(2000, n);
    chk("rr_busy_cycles", 32'(n), 32'd1201);
    chk("rr_nwrites", 32'(q_addr.size()), 32'd1200);
    chk_fill("rr_fill", 0, 1200, 0, 16'h0F20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
